// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM states and parity modes.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_bit_sampler.sv
// RX line synchroniser plus oversample counters and per-bit majority decision.
module uart_bit_sampler #(
    parameter int SAMPLES = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rxd,
    input  logic i_rxpulse,
    input  logic i_clear,
    output logic o_sample,
    output logic o_bit_valid,
    output logic o_bit
);

    localparam int CW = $clog2(SAMPLES);
    localparam int OW = $clog2(SAMPLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic [OW-1:0] r_ones;
    logic          w_last;
    logic [OW-1:0] w_ones_next;

    assign o_sample    = r_sync2;
    assign w_last      = i_rxpulse && (r_cnt == CW'(SAMPLES - 1));
    // The current tick's sample is folded in before the majority compare.
    assign w_ones_next = r_ones + OW'(r_sync2);
    assign o_bit_valid = w_last;
    assign o_bit       = (w_ones_next > OW'(SAMPLES / 2));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
            r_ones  <= '0;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            if (i_clear || w_last) begin
                r_cnt  <= '0;
                r_ones <= '0;
            end else if (i_rxpulse) begin
                r_cnt  <= r_cnt + 1'b1;
                r_ones <= w_ones_next;
            end
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver delivering frames on a valid/ready stream with error pulses.
// Optional break detection (port o_break) is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int SAMPLES   = 3,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rxd,
    input  logic                 i_rxpulse,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_rxsync,
    output logic                 o_busy,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
`ifdef UART_RX_BREAK_DET_EN
    output logic                 o_break,
`endif
    output logic                 o_overrun
);

    localparam int IW = $clog2(DATA_BITS);

    state_t               r_state;
    state_t               w_next;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_word;
    logic                 r_par_fail;
    logic                 r_frame_fail;
    logic                 r_stop_idx;
    logic                 w_sample;
    logic                 w_bit_valid;
    logic                 w_bit;
    logic                 w_clear;
    logic                 w_sync_evt;
    logic                 w_deliver;
    logic                 w_ferr_evt;
    logic                 w_perr_evt;
    logic                 w_stop_last;
    logic                 w_par_exp;
    logic [IW-1:0]        w_pos;
`ifdef UART_RX_BREAK_DET_EN
    logic                 r_nonzero;
    logic                 r_brk;
    logic                 w_brk_cand;
    logic                 w_brk_evt;

    // With one stop bit the first stop decision is also the last, so use it directly.
    assign w_brk_cand = (r_stop_idx == 1'b0) ? (!r_nonzero && !w_bit) : r_brk;
`endif

    uart_bit_sampler #(.SAMPLES(SAMPLES)) u_sampler (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rxd       (i_rxd),
        .i_rxpulse   (i_rxpulse),
        .i_clear     (w_clear),
        .o_sample    (w_sample),
        .o_bit_valid (w_bit_valid),
        .o_bit       (w_bit)
    );

    assign o_busy      = (r_state != ST_IDLE);
    assign w_stop_last = (int'(r_stop_idx) == STOP_BITS - 1);
    assign w_par_exp   = (PARITY == PAR_ODD) ? ~^r_word : ^r_word;
    assign w_pos       = (MSB_FIRST != 0) ? IW'(DATA_BITS - 1) - r_idx : r_idx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_clear    = 1'b0;
        w_sync_evt = 1'b0;
        w_deliver  = 1'b0;
        w_ferr_evt = 1'b0;
        w_perr_evt = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        w_brk_evt  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                // The falling-edge tick is kept as sample 0 of the start bit.
                if (i_rxpulse && !w_sample) w_next  = ST_START;
                else                        w_clear = 1'b1;
            end
            ST_START: begin
                if (w_bit_valid) begin
                    if (!w_bit) begin
                        w_sync_evt = 1'b1;
                        w_next     = ST_DATA;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_bit_valid && (r_idx == IW'(DATA_BITS - 1)))
                    w_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_bit_valid) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_valid && w_stop_last) begin
                    if (r_frame_fail || !w_bit) begin
`ifdef UART_RX_BREAK_DET_EN
                        if (w_brk_cand) w_brk_evt = 1'b1;
                        else
`endif
                        w_ferr_evt = 1'b1;
                        w_next     = ST_WAIT_IDLE;
                    end else if (r_par_fail) begin
                        w_perr_evt = 1'b1;
                        w_next     = ST_IDLE;
                    end else begin
                        w_deliver = 1'b1;
                        w_next    = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (w_bit_valid && w_bit) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx        <= '0;
            r_word       <= '0;
            r_par_fail   <= 1'b0;
            r_frame_fail <= 1'b0;
            r_stop_idx   <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_rxsync     <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            r_nonzero    <= 1'b0;
            r_brk        <= 1'b0;
            o_break      <= 1'b0;
`endif
        end else begin
            o_rxsync     <= w_sync_evt;
            o_frame_err  <= w_ferr_evt;
            o_parity_err <= w_perr_evt;
            o_overrun    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            o_break      <= w_brk_evt;
`endif
            if (w_sync_evt) begin
                r_idx        <= '0;
                r_par_fail   <= 1'b0;
                r_frame_fail <= 1'b0;
                r_stop_idx   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                r_nonzero    <= 1'b0;
`endif
            end
            if (w_bit_valid) begin
                case (r_state)
                    ST_DATA: begin
                        r_word[w_pos] <= w_bit;
                        r_idx         <= r_idx + 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                        r_nonzero     <= r_nonzero | w_bit;
`endif
                    end
                    ST_PARITY: begin
                        r_par_fail <= (w_bit != w_par_exp);
`ifdef UART_RX_BREAK_DET_EN
                        r_nonzero  <= r_nonzero | w_bit;
`endif
                    end
                    ST_STOP: begin
                        r_frame_fail <= r_frame_fail | !w_bit;
                        r_stop_idx   <= r_stop_idx + 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                        if (r_stop_idx == 1'b0) r_brk <= !r_nonzero && !w_bit;
`endif
                    end
                    default: ;
                endcase
            end
            if (w_deliver) begin
                if (!o_valid || i_ready) begin
                    o_data  <= r_word;
                    o_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench: three receiver configurations driven by a frame-level serial model.
module tb_uart_rx_param;

    int cfg_db   [3] = '{8, 7, 5};
    int cfg_s    [3] = '{3, 5, 3};
    int cfg_par  [3] = '{0, 1, 2};
    int cfg_stop [3] = '{1, 2, 1};
    int cfg_msb  [3] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse = 1'b0;
    logic [2:0] rxd = '1;
    logic [2:0] ready = '1;

    logic [7:0] d0;
    logic [6:0] d1;
    logic [4:0] d2;
    logic [2:0] valid, sync, busy, ferr, perr, ovr;
    logic [8:0] dat [3];
`ifdef UART_RX_BREAK_DET_EN
    logic [2:0] brk;
    int         n_brk [3];
`endif

    assign dat[0] = {1'b0, d0};
    assign dat[1] = {2'b0, d1};
    assign dat[2] = {4'b0, d2};

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_BITS(8), .SAMPLES(3), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_rxd(rxd[0]), .i_rxpulse(pulse),
        .o_data(d0), .o_valid(valid[0]), .i_ready(ready[0]), .o_rxsync(sync[0]),
        .o_busy(busy[0]), .o_frame_err(ferr[0]), .o_parity_err(perr[0]),
`ifdef UART_RX_BREAK_DET_EN
        .o_break(brk[0]),
`endif
        .o_overrun(ovr[0]));

    uart_rx_param #(.DATA_BITS(7), .SAMPLES(5), .PARITY(1), .STOP_BITS(2), .MSB_FIRST(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_rxd(rxd[1]), .i_rxpulse(pulse),
        .o_data(d1), .o_valid(valid[1]), .i_ready(ready[1]), .o_rxsync(sync[1]),
        .o_busy(busy[1]), .o_frame_err(ferr[1]), .o_parity_err(perr[1]),
`ifdef UART_RX_BREAK_DET_EN
        .o_break(brk[1]),
`endif
        .o_overrun(ovr[1]));

    uart_rx_param #(.DATA_BITS(5), .SAMPLES(3), .PARITY(2), .STOP_BITS(1), .MSB_FIRST(0)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_rxd(rxd[2]), .i_rxpulse(pulse),
        .o_data(d2), .o_valid(valid[2]), .i_ready(ready[2]), .o_rxsync(sync[2]),
        .o_busy(busy[2]), .o_frame_err(ferr[2]), .o_parity_err(perr[2]),
`ifdef UART_RX_BREAK_DET_EN
        .o_break(brk[2]),
`endif
        .o_overrun(ovr[2]));

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_sync [3], n_ferr [3], n_perr [3], n_ovr [3], n_hs [3];
    logic [8:0] hs_word [3];
    bit         m_valid [3];
    logic [8:0] m_word  [3];

    // Event counters observed mid-cycle, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (sync[i]) n_sync[i]++;
            if (ferr[i]) n_ferr[i]++;
            if (perr[i]) n_perr[i]++;
            if (ovr[i])  n_ovr[i]++;
`ifdef UART_RX_BREAK_DET_EN
            if (brk[i])  n_brk[i]++;
`endif
            if (valid[i] && ready[i]) begin
                n_hs[i]++;
                hs_word[i] = dat[i];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick1(input int d, input logic b);
        rxd[d] = b;
        repeat (3) @(negedge clk);
        pulse = 1'b1;
        @(negedge clk);
        pulse = 1'b0;
    endtask

    task automatic bitt(input int d, input logic b);
        for (int k = 0; k < cfg_s[d]; k++) tick1(d, b);
    endtask

    // Serialise one frame as a transmitter would and check every outcome the rules predict.
    task automatic send_frame(input int d, input logic [8:0] word_in, input bit par_bad,
                              input logic [1:0] stops);
        logic [8:0] word;
        logic       pbit;
        bit         fe, brk_c, deliver;
        int         s_sync, s_ferr, s_perr, s_ovr, s_hs, e_ovr, e_hs, e_ferr;
        word  = word_in & 9'((1 << cfg_db[d]) - 1);
        pbit  = ($countones(word) % 2 == 1) ^ (cfg_par[d] == 2) ^ par_bad;
        fe    = !stops[0] || (cfg_stop[d] == 2 && !stops[1]);
        brk_c = (word == 0) && (cfg_par[d] == 0 || !pbit) && !stops[0];
        deliver = !fe && !(cfg_par[d] != 0 && par_bad);
        s_sync = n_sync[d]; s_ferr = n_ferr[d]; s_perr = n_perr[d];
        s_ovr  = n_ovr[d];  s_hs   = n_hs[d];
`ifdef UART_RX_BREAK_DET_EN
        e_ferr = (fe && !brk_c) ? 1 : 0;
        begin
            int s_brk;
            s_brk = n_brk[d];
`else
        e_ferr = fe ? 1 : 0;
        begin
`endif
            bitt(d, 1'b0);
            for (int i = 0; i < cfg_db[d]; i++)
                bitt(d, (cfg_msb[d] != 0) ? word[cfg_db[d] - 1 - i] : word[i]);
            if (cfg_par[d] != 0) bitt(d, pbit);
            for (int i = 0; i < cfg_stop[d]; i++) bitt(d, stops[i]);
            e_ovr = 0; e_hs = 0;
            if (deliver) begin
                if (m_valid[d]) e_ovr = 1;
                else if (ready[d]) begin
                    e_hs = 1;
                    check("valid_latency", 32'(valid[d]), 32'd1);
                    check("data_at_valid", 32'(dat[d]), 32'(word));
                    @(negedge clk);
                    check("valid_one_cycle", 32'(valid[d]), 32'd0);
                end else begin
                    m_valid[d] = 1'b1;
                    m_word[d]  = word;
                end
            end
            bitt(d, 1'b1);
            bitt(d, 1'b1);
`ifdef UART_RX_BREAK_DET_EN
            check("break_cnt", 32'(n_brk[d] - s_brk), (fe && brk_c) ? 32'd1 : 32'd0);
`endif
        end
        check("rxsync_cnt", 32'(n_sync[d] - s_sync), 32'd1);
        check("frame_err_cnt", 32'(n_ferr[d] - s_ferr), 32'(e_ferr));
        check("parity_err_cnt", 32'(n_perr[d] - s_perr),
              (!fe && cfg_par[d] != 0 && par_bad) ? 32'd1 : 32'd0);
        check("overrun_cnt", 32'(n_ovr[d] - s_ovr), 32'(e_ovr));
        check("handshake_cnt", 32'(n_hs[d] - s_hs), 32'(e_hs));
        if (e_hs == 1) check("handshake_word", 32'(hs_word[d]), 32'(word));
        check("busy_after_frame", 32'(busy[d]), 32'd0);
    endtask

    initial begin
        int s_sync, s_hs, s_ferr;
        for (int i = 0; i < 3; i++) begin
            n_sync[i] = 0; n_ferr[i] = 0; n_perr[i] = 0; n_ovr[i] = 0; n_hs[i] = 0;
            hs_word[i] = '0; m_valid[i] = 1'b0; m_word[i] = '0;
`ifdef UART_RX_BREAK_DET_EN
            n_brk[i] = 0;
`endif
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_data", 32'(dat[i]), 32'd0);
            check("reset_flags", 32'({valid[i], sync[i], busy[i], ferr[i], perr[i], ovr[i]}), 32'd0);
        end
        bitt(0, 1'b1);

        // 8N1 basic frame
        send_frame(0, 9'hA5, 1'b0, 2'b11);

        // Even parity: wrong parity then correct parity
        send_frame(1, 9'h07, 1'b1, 2'b11);
        check("parity_no_valid", 32'(valid[1]), 32'd0);
        send_frame(1, 9'h07, 1'b0, 2'b11);

        // Frame error, line held in break, then recovery
        s_sync = n_sync[0]; s_ferr = n_ferr[0];
        bitt(0, 1'b0);
        for (int i = 0; i < 8; i++) bitt(0, 1'b1);
        bitt(0, 1'b0);
        for (int i = 0; i < 3; i++) bitt(0, 1'b0);
        check("ferr_pulse", 32'(n_ferr[0] - s_ferr), 32'd1);
        check("no_retrigger", 32'(n_sync[0] - s_sync), 32'd1);
        check("busy_in_break", 32'(busy[0]), 32'd1);
        bitt(0, 1'b1);
        bitt(0, 1'b1);
        send_frame(0, 9'h3C, 1'b0, 2'b11);

        // Overrun: two frames unaccepted, then a single handshake of the first
        ready[0] = 1'b0;
        send_frame(0, 9'h11, 1'b0, 2'b11);
        send_frame(0, 9'h22, 1'b0, 2'b11);
        check("overrun_hold_data", 32'(dat[0]), 32'h11);
        check("overrun_hold_valid", 32'(valid[0]), 32'd1);
        s_hs = n_hs[0];
        ready[0] = 1'b1;
        m_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("drain_hs_cnt", 32'(n_hs[0] - s_hs), 32'd1);
        check("drain_hs_word", 32'(hs_word[0]), 32'h11);
        check("drain_valid_low", 32'(valid[0]), 32'd0);

        // Glitch: one low sample in the start window
        s_sync = n_sync[0]; s_hs = n_hs[0];
        tick1(0, 1'b0);
        check("glitch_busy", 32'(busy[0]), 32'd1);
        tick1(0, 1'b1);
        tick1(0, 1'b1);
        bitt(0, 1'b1);
        check("glitch_no_sync", 32'(n_sync[0] - s_sync), 32'd0);
        check("glitch_no_out", 32'(n_hs[0] - s_hs), 32'd0);
        check("glitch_idle", 32'(busy[0]), 32'd0);

        // Reset mid-DATA
        bitt(0, 1'b0);
        for (int i = 0; i < 3; i++) bitt(0, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_data", 32'(dat[0]), 32'd0);
        check("midrst_flags", 32'({valid[0], sync[0], busy[0], ferr[0], perr[0], ovr[0]}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;
        bitt(0, 1'b1);
        bitt(0, 1'b1);
        send_frame(0, 9'h5A, 1'b0, 2'b11);

        // Randomised frames across all configurations
        for (int r = 0; r < 36; r++) begin
            int         d;
            logic [8:0] w;
            bit         pb;
            logic [1:0] st;
            d  = r % 3;
            w  = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom);
            pb = (cfg_par[d] != 0) && ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            send_frame(d, w, pb, st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Oversampled by an external tick `i_rxpulse`, which runs at SAMPLES x baud and is generated by the shared baud generator.
- Configurable data width, bit order, parity, stop-bit count and samples per bit.
- Delivers frames on a valid/ready stream, with per-cause error pulses; sits between the pad synchroniser-free RX pin and the UART RX FIFO.

Parameters:
- DATA_BITS, 8, data bits per frame, 5..9.
- SAMPLES, 3, `i_rxpulse` ticks per bit; odd, 3..31.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.
- MSB_FIRST, 0, 1 = first received data bit lands in `o_data[DATA_BITS-1]`.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset.
- i_rxd  in  1  asynchronous serial line, idle high.
- i_rxpulse  in  1  oversample tick, one i_clk wide.
- o_data  out  DATA_BITS  received word.
- o_valid  out  1  o_data valid.
- i_ready  in  1  consumer accepts.
- o_rxsync  out  1  one-cycle pulse when a start bit is validated.
- o_busy  out  1  high in any state other than IDLE.
- o_frame_err  out  1  one-cycle pulse: a stop bit was sampled 0.
- o_parity_err  out  1  one-cycle pulse: parity mismatch.
- o_overrun  out  1  one-cycle pulse: a frame completed while the previous word was unaccepted.

Behaviour:
- Clock and reset: one clock, `i_clk`; reset `i_rst` is asynchronous and active-high.
  - Reset forces state IDLE and clears all counters.
  - Synchroniser flops reset to 1.
  - Reset values: `o_data` = 0, `o_valid` = 0, and `o_rxsync`, `o_busy` and all error outputs = 0.
  - Reset mid-frame aborts the frame immediately; no partial output is produced.
- Input sync: `i_rxd` passes through 2 flops. Only the synchronised value is sampled, and only on cycles where `i_rxpulse` = 1.
- Bit decision:
  - A sample counter runs 0..SAMPLES-1 and a ones-counter of width clog2(SAMPLES+1) accumulates the samples.
  - When the sample counter reaches SAMPLES-1, bit = (ones > SAMPLES/2). Both counters then clear and the bit is consumed by the FSM in the same cycle.
- FSM:
  - IDLE: on a tick with sampled 0, this counts as sample 0 of the start bit; go to START.
  - START: at the bit decision:
    - 0: pulse `o_rxsync`, clear the bit index, go to DATA.
    - 1: false start; return to IDLE silently.
  - DATA: store each decided bit.
    - Order: LSB-first into index 0..DATA_BITS-1, or MSB-first from index DATA_BITS-1 down.
    - After DATA_BITS bits, go to PARITY (if PARITY != 0) or STOP.
  - PARITY: compare the decided bit with the XOR of the data bits.
    - Even: expected bit = XOR. Odd: expected bit = ~XOR.
    - Record a mismatch flag, then go to STOP.
  - STOP: STOP_BITS decisions; any 0 sets the frame-fail flag.
    - After the last stop bit, evaluate the frame in that cycle:
      - Frame fail: pulse `o_frame_err`, discard the word, go to WAIT_IDLE.
      - Else parity fail: pulse `o_parity_err`, discard the word, go to IDLE.
      - Else deliver the word and go to IDLE.
    - Frame error takes priority; `o_parity_err` is not pulsed alongside it.
  - WAIT_IDLE: stay until one full bit window decides 1, then go to IDLE. This prevents re-triggering inside a break.
- Stream:
  - Delivering a word sets `o_valid` = 1 and loads `o_data`.
  - Both hold until the cycle where `o_valid` & `i_ready`; `o_valid` clears on the next edge.
  - Delivery on the same cycle as a handshake: the new word loads and `o_valid` stays 1; no overrun.
  - Delivery while `o_valid` = 1 with no handshake that cycle: pulse `o_overrun`, drop the new word and keep the old one.
- Latency: `o_valid` rises 1 `i_clk` after the tick that completes the last stop bit.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- When defined:
  - Adds port `o_break` (out, 1).
  - If all data bits, any parity bit, and the first stop bit decide 0, pulse `o_break` instead of `o_frame_err`. The WAIT_IDLE transition is unchanged.
- When undefined: the port is absent and that case reports `o_frame_err`.

Decomposition:
- Package uart_pkg holds:
  - State encoding localparams: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - Parity-mode constants: PAR_NONE, PAR_EVEN, PAR_ODD.
- Sub-module uart_bit_sampler holds the synchroniser, the sample and ones counters, and the majority decision.
  - Outputs: bit_valid pulse and bit value.
  - Input: a clear signal, asserted by the FSM on entry to IDLE.
- FSM and stream logic live in uart_rx_param.

Test Plan:
- 8N1, SAMPLES = 3, `i_ready` = 1, send 0xA5 → one `o_rxsync`, then `o_valid` for 1 cycle with `o_data` = 0xA5; no error pulses.
- PARITY = 1, send 0x07 with parity bit 0 → `o_parity_err` 1 cycle, `o_valid` stays 0; next frame 0x07 with parity 1 → `o_data` = 0x07.
- Stop bit forced 0 → `o_frame_err` 1 cycle; the line is held low 3 more bit times and produces no further `o_rxsync`; after the line returns high, 0x3C is received correctly.
- `i_ready` = 0, send 0x11 then 0x22 → `o_data` stays 0x11 and `o_overrun` pulses once; raise `i_ready` → single handshake of 0x11.
- Glitch: line low for 1 tick of the start window (majority 1) → no `o_rxsync`, no output, `o_busy` returns to 0.
- Assert `i_rst` mid-DATA → outputs at reset values in the same cycle; a following frame 0x5A is received correctly.
